// File: rtl/cdec_monitor_pkg.sv
// Shared types for the CDECv monitor-side execution controller.
package cdec_monitor_pkg;

    typedef enum logic [2:0] {
        STOP,
        RUN,
        STEP_EXIT,
        STEP_WAIT,
        HALT
    } state_t;

endpackage

// File: rtl/run_step_controller_input_sync.sv
// Multi-stage synchronizer for an asynchronous level, plus a one-clock rising-edge pulse.
module input_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic sync_out,
    output logic rise_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            last_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_out   = sync_q[SYNC_STAGES-1];
    assign rise_pulse = sync_out & ~last_q;

endmodule

// File: rtl/run_step_controller.sv
// Run / single-step / breakpoint / halt controller producing the CPU clock enable,
// with instruction and enabled-cycle counters for the monitor.
module run_step_controller
    import cdec_monitor_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run_sw,
    input  logic             step_btn,
    input  logic             clr_cnt,
    input  logic             dbg_F0,
    input  logic             dbg_halt,
    input  logic [7:0]       pc,
    input  logic             bp_en,
    input  logic [7:0]       bp_addr,
    output logic             cpu_en,
    output logic             running,
    output logic             halted,
    output logic             bp_hit,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] cycle_count
);

    state_t           state_q, state_d;
    logic             run_s, run_rise;
    logic             step_s, step_pulse;
    logic             left_f0_q;
    logic             bp_hit_q;
    logic             f0_prev_q;
    logic             bp_match;
    logic             bp_stop;
    logic [CNT_W-1:0] instr_q, cycle_q;

    input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_run_sync (
        .clock      (clock),
        .reset      (reset),
        .async_in   (run_sw),
        .sync_out   (run_s),
        .rise_pulse (run_rise)
    );

    input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_step_sync (
        .clock      (clock),
        .reset      (reset),
        .async_in   (step_btn),
        .sync_out   (step_s),
        .rise_pulse (step_pulse)
    );

    // Run is level-sensitive and step only needs its edge; the other outputs are spare.
    logic unused_sync;
    assign unused_sync = run_rise ^ step_s;

    // left_f0 keeps a resume at the breakpoint PC from stopping again before the CPU moves on.
    assign bp_match = left_f0_q & dbg_F0 & bp_en & (pc == bp_addr);
    assign bp_stop  = (state_q == RUN) & ~dbg_halt & bp_match;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= STOP;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            STOP: begin
                if (run_s)           state_d = RUN;
                else if (step_pulse) state_d = STEP_EXIT;
            end
            RUN: begin
                if (dbg_halt)        state_d = HALT;
                else if (bp_match)   state_d = STOP;
                else if (!run_s)     state_d = dbg_F0 ? STOP : STEP_WAIT;
            end
            STEP_EXIT: begin
                if (dbg_halt)        state_d = HALT;
                else if (!dbg_F0)    state_d = STEP_WAIT;
            end
            STEP_WAIT: begin
                if (dbg_halt)        state_d = HALT;
                else if (dbg_F0)     state_d = STOP;
            end
            HALT:    state_d = HALT;
            default: state_d = STOP;
        endcase
    end

    always_comb begin
        cpu_en  = 1'b0;
        running = 1'b0;
        halted  = 1'b0;
        unique case (state_q)
            RUN: begin
                cpu_en  = 1'b1;
                running = 1'b1;
            end
            STEP_EXIT, STEP_WAIT: cpu_en = 1'b1;
            HALT:                 halted = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            left_f0_q <= 1'b0;
            bp_hit_q  <= 1'b0;
            f0_prev_q <= 1'b0;
        end else begin
            f0_prev_q <= dbg_F0;
            if (state_q != RUN && state_d == RUN) begin
                left_f0_q <= 1'b0;
            end else if (state_q == RUN && !dbg_F0) begin
                left_f0_q <= 1'b1;
            end
            if (state_q == STOP && (state_d == RUN || state_d == STEP_EXIT)) begin
                bp_hit_q <= 1'b0;
            end else if (bp_stop) begin
                bp_hit_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            instr_q <= '0;
            cycle_q <= '0;
        end else if (clr_cnt) begin
            instr_q <= '0;
            cycle_q <= '0;
        end else if (cpu_en) begin
            cycle_q <= cycle_q + CNT_W'(1);
            if (dbg_F0 && !f0_prev_q) begin
                instr_q <= instr_q + CNT_W'(1);
            end
        end
    end

    assign bp_hit      = bp_hit_q;
    assign instr_count = instr_q;
    assign cycle_count = cycle_q;

endmodule

// File: tb/tb_run_step_controller.sv
// Self-checking bench: a 3-clock-per-instruction CPU model drives the controller, and a
// behavioural model of the controller is compared against the DUT after every rising edge.
module tb_run_step_controller;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned SYNC  = 2;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             run_sw = 1'b0;
    logic             step_btn = 1'b0;
    logic             clr_cnt = 1'b0;
    logic             dbg_F0, dbg_halt;
    logic [7:0]       pc;
    logic             bp_en = 1'b0;
    logic [7:0]       bp_addr = 8'h00;
    logic             cpu_en, running, halted, bp_hit;
    logic [CNT_W-1:0] instr_count, cycle_count;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    run_step_controller #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC)) dut (
        .clock       (clock),
        .reset       (reset),
        .run_sw      (run_sw),
        .step_btn    (step_btn),
        .clr_cnt     (clr_cnt),
        .dbg_F0      (dbg_F0),
        .dbg_halt    (dbg_halt),
        .pc          (pc),
        .bp_en       (bp_en),
        .bp_addr     (bp_addr),
        .cpu_en      (cpu_en),
        .running     (running),
        .halted      (halted),
        .bp_hit      (bp_hit),
        .instr_count (instr_count),
        .cycle_count (cycle_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // CPU model: F0 -> F1 -> F2 -> F0, advancing on falling edges while enabled.
    int         cpu_phase;
    logic       cpu_hlt;
    logic [7:0] cpu_pc;
    logic       halt_arm = 1'b0;
    logic [7:0] halt_pc = 8'h00;

    assign dbg_F0   = !cpu_hlt && cpu_phase == 0;
    assign dbg_halt = cpu_hlt;
    assign pc       = cpu_pc;

    always @(negedge clock or negedge reset) begin
        if (!reset) begin
            cpu_phase <= 0;
            cpu_pc    <= 8'h00;
            cpu_hlt   <= 1'b0;
        end else if (cpu_en && !cpu_hlt) begin
            if (cpu_phase == 0 && halt_arm && cpu_pc == halt_pc) begin
                cpu_hlt <= 1'b1;
            end else if (cpu_phase == 2) begin
                cpu_phase <= 0;
                cpu_pc    <= cpu_pc + 8'd1;
            end else begin
                cpu_phase <= cpu_phase + 1;
            end
        end
    end

    // Controller model: enabled / free-running / past-the-fetch flags and plain integer counters.
    bit m_en, m_free, m_left, m_halt, m_bp, m_prevf0;
    int m_cyc, m_ins;
    bit run_h [8];
    bit step_h[8];

    task automatic model_reset();
        m_en = 0; m_free = 0; m_left = 0; m_halt = 0; m_bp = 0; m_prevf0 = 0;
        m_cyc = 0; m_ins = 0;
        for (int i = 0; i < 8; i++) begin
            run_h[i]  = 0;
            step_h[i] = 0;
        end
    endtask

    task automatic model_step(input bit rsw, input bit sbtn, input bit clr, input bit f0,
                              input bit hlt, input logic [7:0] p, input bit ben,
                              input logic [7:0] badr);
        bit rs, sp;
        rs = run_h[SYNC-1];
        sp = step_h[SYNC-1] && !step_h[SYNC];
        if (clr) begin
            m_cyc = 0;
            m_ins = 0;
        end else if (m_en) begin
            m_cyc = (m_cyc + 1) % 65536;
            if (f0 && !m_prevf0) m_ins = (m_ins + 1) % 65536;
        end
        m_prevf0 = f0;
        if (m_halt) begin
        end else if (!m_en) begin
            if (rs) begin
                m_en = 1; m_free = 1; m_left = 0; m_bp = 0;
            end else if (sp) begin
                m_en = 1; m_free = 0; m_left = 0; m_bp = 0;
            end
        end else if (hlt) begin
            m_halt = 1; m_en = 0;
        end else if (m_free) begin
            if (m_left && f0 && ben && p == badr) begin
                m_en = 0; m_bp = 1;
            end else if (!rs) begin
                if (f0) m_en = 0;
                else begin
                    m_free = 0; m_left = 1;
                end
            end else if (!f0) begin
                m_left = 1;
            end
        end else begin
            if (!m_left) begin
                if (!f0) m_left = 1;
            end else if (f0) begin
                m_en = 0;
            end
        end
        for (int i = 7; i > 0; i--) begin
            run_h[i]  = run_h[i-1];
            step_h[i] = step_h[i-1];
        end
        run_h[0]  = rsw;
        step_h[0] = sbtn;
    endtask

    always @(negedge reset) model_reset();

    always @(posedge clock) begin
        if (!reset) model_reset();
        else model_step(run_sw, step_btn, clr_cnt, dbg_F0, dbg_halt, pc, bp_en, bp_addr);
        #1;
        chk("cpu_en", {31'd0, cpu_en}, {31'd0, m_en});
        chk("running", {31'd0, running}, {31'd0, m_en && m_free});
        chk("halted", {31'd0, halted}, {31'd0, m_halt});
        chk("bp_hit", {31'd0, bp_hit}, {31'd0, m_bp});
        chk("instr_count", {16'd0, instr_count}, m_ins);
        chk("cycle_count", {16'd0, cycle_count}, m_cyc);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_async_cpu_en", {31'd0, cpu_en}, 32'd0);
        @(negedge clock);
        run_sw   = 1'b0;
        step_btn = 1'b0;
        clr_cnt  = 1'b0;
        reset    = 1'b1;
    endtask

    initial begin
        bit found;
        int en_clocks;
        model_reset();
        tick(2);
        reset = 1'b1;

        // Reset asserted while running
        run_sw = 1'b1;
        tick(10);
        chk("t1_running", {31'd0, running}, 32'd1);
        do_reset();
        tick(2);
        chk("t1_stop_running", {31'd0, running}, 32'd0);
        chk("t1_cycle_zero", {16'd0, cycle_count}, 32'd0);
        chk("t1_instr_zero", {16'd0, instr_count}, 32'd0);
        chk("t1_bp_hit", {31'd0, bp_hit}, 32'd0);

        // Single step from F0
        step_btn  = 1'b1;
        en_clocks = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (i == 3) step_btn = 1'b0;
            if (cpu_en) en_clocks++;
        end
        chk("t2_enabled_clocks", en_clocks, 32'd3);
        chk("t2_instr", {16'd0, instr_count}, 32'd1);
        chk("t2_cycle", {16'd0, cycle_count}, 32'd3);
        chk("t2_pc", {24'd0, pc}, 32'd1);

        // Breakpoint at 05, then resume past it
        do_reset();
        bp_en   = 1'b1;
        bp_addr = 8'h05;
        run_sw  = 1'b1;
        found   = 0;
        begin
            bit seen_run;
            seen_run = 0;
            for (int i = 0; i < 100 && !found; i++) begin
                @(negedge clock);
                if (running) seen_run = 1;
                if (seen_run && !cpu_en) found = 1;
            end
        end
        chk("t3_bp_stop_seen", {31'd0, found}, 32'd1);
        chk("t3_bp_pc", {24'd0, pc}, 32'h05);
        chk("t3_bp_f0", {31'd0, dbg_F0}, 32'd1);
        chk("t3_bp_hit", {31'd0, bp_hit}, 32'd1);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clock);
            if (pc == 8'h06) found = 1;
        end
        chk("t3_resume_past_bp", {31'd0, found}, 32'd1);
        chk("t3_bp_hit_cleared", {31'd0, bp_hit}, 32'd0);
        run_sw = 1'b0;
        bp_en  = 1'b0;
        tick(10);

        // Halt detection, inputs ignored afterwards
        do_reset();
        halt_arm = 1'b1;
        halt_pc  = 8'h03;
        run_sw   = 1'b1;
        found    = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clock);
            if (halted) found = 1;
        end
        chk("t4_halt_seen", {31'd0, found}, 32'd1);
        chk("t4_cpu_en", {31'd0, cpu_en}, 32'd0);
        run_sw = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step_btn = 1'b1;
            tick(4);
            step_btn = 1'b0;
            tick(4);
        end
        run_sw = 1'b1;
        tick(10);
        chk("t4_still_halted", {31'd0, halted}, 32'd1);
        chk("t4_still_disabled", {31'd0, cpu_en}, 32'd0);
        halt_arm = 1'b0;

        // run_sw dropped mid-instruction
        do_reset();
        run_sw = 1'b1;
        found  = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clock);
            if (running && pc >= 8'h02 && !dbg_F0) found = 1;
        end
        chk("t5_mid_instr", {31'd0, found}, 32'd1);
        run_sw = 1'b0;
        found  = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clock);
            if (!cpu_en) found = 1;
        end
        chk("t5_stopped", {31'd0, found}, 32'd1);
        chk("t5_stop_at_f0", {31'd0, dbg_F0}, 32'd1);

        // Cycle counter wrap and clear priority
        do_reset();
        run_sw = 1'b1;
        found  = 0;
        for (int i = 0; i < 70000 && !found; i++) begin
            @(negedge clock);
            if (cycle_count == 16'hFFFF) found = 1;
        end
        chk("t6_reach_ffff", {31'd0, found}, 32'd1);
        tick(1);
        chk("t6_wrap", {16'd0, cycle_count}, 32'd0);
        clr_cnt = 1'b1;
        tick(1);
        clr_cnt = 1'b0;
        chk("t6_clr_cycle", {16'd0, cycle_count}, 32'd0);
        chk("t6_clr_instr", {16'd0, instr_count}, 32'd0);
        run_sw = 1'b0;
        tick(10);

        // Randomized operation
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            if ($urandom_range(0, 19) == 0) run_sw = ~run_sw;
            if ($urandom_range(0, 5) == 0) step_btn = ~step_btn;
            clr_cnt = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 29) == 0) begin
                bp_en   = $urandom_range(0, 1) == 1;
                bp_addr = 8'($urandom_range(0, 7));
            end
            if (halted || $urandom_range(0, 399) == 0) begin
                halt_arm = $urandom_range(0, 3) == 0;
                halt_pc  = 8'($urandom_range(0, 20));
                do_reset();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
